v_mul_seq: RTL and testbench
============================

// Module: v_mul_seq
// PURPOSE
// Vector-multiply sequencer, directly upstream of the lane multiplier (v_mul).
// Takes one vector multiply instruction (base regs, vl, sew) and walks the operand
// words in the 32-bit-word vector register file. Feeds each word pair to the multiplier,
// tracks the multiplier pipeline latency, and writes products back with tail byte masking.
// PARAMETERS
// MUL_LAT  1  cycles from mul_op_A/B valid to mul_result valid (multiplier pipeline depth)
// ADDR_W   5  register-file word address width (32 words)
// VL_W     8  width of vl_in (element count)
// PORTS
// clk            in   1       clock
// rst            in   1       synchronous reset, active-high
// start          in   1       launch instruction; sampled only when busy=0
// sew_in         in   2       00=8b, 01=16b, 10=32b, 11=illegal
// vl_in          in   VL_W    element count
// vs1_base       in   ADDR_W  first word of operand A
// vs2_base       in   ADDR_W  first word of operand B
// vd_base        in   ADDR_W  first word of destination
// busy           out  1       instruction in flight
// done           out  1       1-cycle completion pulse
// err            out  1       valid with done; illegal sew
// rf_rd_addr_a   out  ADDR_W  read addr A; sync RAM, data next cycle
// rf_rd_addr_b   out  ADDR_W  read addr B
// rf_rd_data_a   in   32      read data A
// rf_rd_data_b   in   32      read data B
// mul_op_A       out  32      = rf_rd_data_a (combinational pass-through)
// mul_op_B       out  32      = rf_rd_data_b
// mul_sew        out  2       latched sew of current instruction
// mul_result     in   32      packed lane products from multiplier
// rf_wr_en       out  1       write strobe
// rf_wr_addr     out  ADDR_W  write address
// rf_wr_data     out  32      = mul_result
// rf_wr_be       out  4       byte enables
// BEHAVIOUR
// - Reset: busy=0, done=0, err=0, rf_wr_en=0, rd/wr addrs=0, mul_sew=0, FSM=IDLE, tag pipe cleared.
// - epw (elems/word) = 4/2/1 for sew 00/01/10. N = ceil(vl/epw), saturated at 2^ADDR_W.
// - FSM IDLE->ISSUE on start; ISSUE->DRAIN after word N-1 issued; DRAIN->IDLE when tag pipe empty.
// - Timing: start in cycle 0. Word i addr driven cycle 1+i. Data at mul_op cycle 2+i.
//   Write in cycle 2+i+MUL_LAT. done at cycle N+2+MUL_LAT, busy falls the same cycle.
// - Tag pipe: depth 1+MUL_LAT shift reg of {valid, word idx, be}; rf_wr_en = tail valid.
// - Address = base + i, mod 2^ADDR_W (wrap allowed, no error).
// - be: full words 4'b1111. Last word with rem r=vl mod epw != 0:
//   sew00 -> (1<<r)-1; sew01 -> 4'b0011. Tail bytes are left undisturbed.
// - vl=0 or sew=11: no reads/writes; done (err=1 if sew=11) pulses in cycle 1; busy stays 0.
// - start while busy=1: ignored. start in a done cycle: accepted (busy=0 then).
// - rst mid-operation: in-flight tags dropped, no further writes, no done pulse.
// - Inputs sew/vl/bases latched at start; later changes have no effect.
// TESTING (MUL_LAT=1)
// sew=00 vl=8, A=0x04030201,0x08070605 B=0x02020202 x2
//   -> writes 0x08060402@vd, 0x100E0C0A@vd+1, be=1111, cycles 3,4; done cycle 5.
// sew=00 vl=5 -> 2 writes, second be=4'b0001. sew=01 vl=3 -> be 1111 then 0011.
// vl=0 -> done cycle 1, err=0, no rf_wr_en. sew=11 vl=4 -> done+err cycle 1, no access.
// sew=10 vl=2 vd_base=31 -> writes to addr 31 then 0. Products 0x7FFF*0x3 -> 0x00017FFD.
// rst high in cycle 3 of vl=16 sew=00 -> rf_wr_en=0 and busy=0 from cycle 4; no done.
// start held during busy -> ignored; start in the done cycle -> second op runs, done again.

Source files
------------

// File: rtl/v_mul_seq.sv
// Vector-multiply sequencer: walks operand words of one vector multiply, feeds the
// lane multiplier, and writes products back through a latency-matched tag pipe.
module v_mul_seq #(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned VL_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        sew_in,
    input  logic [VL_W-1:0]   vl_in,
    input  logic [ADDR_W-1:0] vs1_base,
    input  logic [ADDR_W-1:0] vs2_base,
    input  logic [ADDR_W-1:0] vd_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] rf_rd_addr_a,
    output logic [ADDR_W-1:0] rf_rd_addr_b,
    input  logic [31:0]       rf_rd_data_a,
    input  logic [31:0]       rf_rd_data_b,
    output logic [31:0]       mul_op_A,
    output logic [31:0]       mul_op_B,
    output logic [1:0]        mul_sew,
    input  logic [31:0]       mul_result,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [31:0]       rf_wr_data,
    output logic [3:0]        rf_wr_be
);
    localparam int unsigned DEPTH     = MUL_LAT + 1;
    localparam int unsigned TAIL      = DEPTH - 1;
    localparam int unsigned CNT_W     = ((VL_W > ADDR_W) ? VL_W : ADDR_W) + 1;
    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [1:0]        sew_q, sew_d;
    logic [ADDR_W-1:0] vd_q, vd_d, idx_q, idx_d, last_q, last_d;
    logic [3:0]        tail_be_q, tail_be_d;

    // Tag pipe: one entry per issued word, tail aligns with mul_result.
    logic [DEPTH-1:0]  tv_q, tv_d;
    logic [ADDR_W-1:0] ta_q [DEPTH];
    logic [ADDR_W-1:0] ta_d [DEPTH];
    logic [3:0]        tb_q [DEPTH];
    logic [3:0]        tb_d [DEPTH];

    logic [CNT_W-1:0]  vl_ext, n_raw;
    logic [1:0]        rem;
    logic              sat;
    logic [ADDR_W-1:0] last_idx_c;
    logic [3:0]        tail_be_c;
    logic              push, pending;
    logic [ADDR_W-1:0] push_addr;
    logic [3:0]        push_be;

    assign vl_ext = CNT_W'(vl_in);

    // Word count, last word index and tail byte mask of the incoming instruction.
    always_comb begin
        n_raw = vl_ext;
        rem   = 2'b00;
        case (sew_in)
            2'b00: begin
                n_raw = (vl_ext + CNT_W'(3)) >> 2;
                rem   = vl_in[1:0];
            end
            2'b01: begin
                n_raw = (vl_ext + CNT_W'(1)) >> 1;
                rem   = {1'b0, vl_in[0]};
            end
            default: begin
                n_raw = vl_ext;
                rem   = 2'b00;
            end
        endcase
        sat        = n_raw > CNT_W'(MAX_WORDS);
        last_idx_c = sat ? ADDR_W'(MAX_WORDS - 1) : ADDR_W'(n_raw - CNT_W'(1));
        tail_be_c  = 4'b1111;
        if (!sat && rem != 2'b00) begin
            tail_be_c = (sew_in == 2'b00) ? ((4'b0001 << rem) - 4'b0001) : 4'b0011;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_a_d    = rd_a_q;
        rd_b_d    = rd_b_q;
        sew_d     = sew_q;
        vd_d      = vd_q;
        idx_d     = idx_q;
        last_d    = last_q;
        tail_be_d = tail_be_q;
        push      = 1'b0;
        push_addr = vd_q + idx_q;
        push_be   = (idx_q == last_q) ? tail_be_q : 4'b1111;
        pending   = 1'b0;
        for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
            pending = pending | tv_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (vl_in == '0 || sew_in == 2'b11) begin
                        done_d = 1'b1;
                        err_d  = (sew_in == 2'b11);
                    end else begin
                        state_d   = ST_ISSUE;
                        rd_a_d    = vs1_base;
                        rd_b_d    = vs2_base;
                        sew_d     = sew_in;
                        vd_d      = vd_base;
                        idx_d     = '0;
                        last_d    = last_idx_c;
                        tail_be_d = tail_be_c;
                    end
                end
            end
            ST_ISSUE: begin
                push = 1'b1;
                if (idx_q == last_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    idx_d  = idx_q + ADDR_W'(1);
                    rd_a_d = rd_a_q + ADDR_W'(1);
                    rd_b_d = rd_b_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Tail entry writes this cycle; finish once nothing is behind it.
                if (!pending) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tv_d[0] = push;
        ta_d[0] = push_addr;
        tb_d[0] = push_be;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            tv_d[k] = tv_q[k-1];
            ta_d[k] = ta_q[k-1];
            tb_d[k] = tb_q[k-1];
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            sew_q     <= 2'b00;
            vd_q      <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            tail_be_q <= 4'b0000;
            tv_q      <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ta_q[k] <= '0;
                tb_q[k] <= 4'b0000;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_a_q    <= rd_a_d;
            rd_b_q    <= rd_b_d;
            sew_q     <= sew_d;
            vd_q      <= vd_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            tail_be_q <= tail_be_d;
            tv_q      <= tv_d;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ta_q[k] <= ta_d[k];
                tb_q[k] <= tb_d[k];
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rf_rd_addr_a = rd_a_q;
    assign rf_rd_addr_b = rd_b_q;
    assign mul_op_A     = rf_rd_data_a;
    assign mul_op_B     = rf_rd_data_b;
    assign mul_sew      = sew_q;
    assign rf_wr_en     = tv_q[TAIL];
    assign rf_wr_addr   = ta_q[TAIL];
    assign rf_wr_be     = tb_q[TAIL];
    assign rf_wr_data   = mul_result;
endmodule

// File: tb/tb_v_mul_seq.sv
// Bench for v_mul_seq: register file and 1-cycle lane multiplier models around the DUT,
// expected writes derived element by element from the instruction.
module tb_v_mul_seq;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  sew_in;
    logic [7:0]  vl_in;
    logic [4:0]  vs1_base, vs2_base, vd_base;
    logic        busy, done, err;
    logic [4:0]  rf_rd_addr_a, rf_rd_addr_b;
    logic [31:0] rf_rd_data_a, rf_rd_data_b;
    logic [31:0] mul_op_A, mul_op_B;
    logic [1:0]  mul_sew;
    logic [31:0] mul_result;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [3:0]  rf_wr_be;

    logic [31:0] rf [32];
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    v_mul_seq #(.MUL_LAT(1), .ADDR_W(5), .VL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sew_in(sew_in), .vl_in(vl_in),
        .vs1_base(vs1_base), .vs2_base(vs2_base), .vd_base(vd_base),
        .busy(busy), .done(done), .err(err),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .mul_op_A(mul_op_A), .mul_op_B(mul_op_B), .mul_sew(mul_sew),
        .mul_result(mul_result), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .rf_wr_be(rf_wr_be)
    );

    function automatic logic [31:0] lane_mul(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] sew);
        logic [31:0] r;
        r = '0;
        case (sew)
            2'b00: for (int l = 0; l < 4; l++) r[8*l +: 8] = a[8*l +: 8] * b[8*l +: 8];
            2'b01: for (int l = 0; l < 2; l++) r[16*l +: 16] = a[16*l +: 16] * b[16*l +: 16];
            default: r = a * b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Sync-read register file with byte-enabled writes, plus the multiplier stage.
    always_ff @(posedge clk) begin
        rf_rd_data_a <= rf[rf_rd_addr_a];
        rf_rd_data_b <= rf[rf_rd_addr_b];
        mul_result   <= lane_mul(mul_op_A, mul_op_B, mul_sew);
        if (ld_en) rf[ld_addr] <= ld_data;
        if (rf_wr_en) begin
            for (int k = 0; k < 4; k++)
                if (rf_wr_be[k]) rf[rf_wr_addr][8*k +: 8] <= rf_wr_data[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 5'(a); ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) load(i, $urandom);
    endtask

    // One instruction end to end; chkd=0 skips data checks where regions overlap.
    task automatic run_op(input logic [1:0] sew, input int vl, input int b1, input int b2,
                          input int bd, input bit chkd);
        logic [31:0] snap [32];
        longint unsigned ed [32];
        longint unsigned em [32];
        logic [3:0] ebe [32];
        logic [4:0] prev_rd;
        int sz, epw, nw, cyc, wc, dc;
        bit trivial;
        logic er, bsy1;
        trivial = (vl == 0) || (sew == 2'b11);
        for (int i = 0; i < 32; i++) begin snap[i] = rf[i]; ed[i] = 0; em[i] = 0; end
        nw = 0;
        if (!trivial) begin
            sz  = 8 << sew;
            epw = 32 / sz;
            nw  = (vl + epw - 1) / epw;
            if (nw > 32) nw = 32;
            for (int e = 0; e < vl; e++) begin
                longint unsigned msk, av, bv;
                int w, ln;
                w = e / epw;
                if (w >= 32) break;
                ln  = e % epw;
                msk = (64'd1 << sz) - 1;
                av  = (longint'(snap[(b1 + w) % 32]) >> (ln * sz)) & msk;
                bv  = (longint'(snap[(b2 + w) % 32]) >> (ln * sz)) & msk;
                ed[w] = ed[w] | (((av * bv) & msk) << (ln * sz));
                em[w] = em[w] | (msk << (ln * sz));
            end
            for (int w = 0; w < 32; w++)
                for (int k = 0; k < 4; k++) ebe[w][k] = em[w][8*k];
        end
        prev_rd = rf_rd_addr_a;
        sew_in = sew; vl_in = 8'(vl);
        vs1_base = 5'(b1); vs2_base = 5'(b2); vd_base = 5'(bd);
        start = 1'b1;
        tick();
        start = 1'b0;
        sew_in = 2'($urandom); vl_in = 8'($urandom);
        vs1_base = 5'($urandom); vs2_base = 5'($urandom); vd_base = 5'($urandom);
        bsy1 = busy;
        cyc = 1; wc = 0; dc = -1; er = 1'b0;
        while (dc < 0 && cyc < 300) begin
            if (rf_wr_en) begin
                if (wc < 32) begin
                    chk("wr_addr", 32'(rf_wr_addr), 32'((bd + wc) % 32));
                    chk("wr_be", 32'(rf_wr_be), 32'(ebe[wc]));
                    chk("wr_cycle", 32'(cyc), 32'(wc + 3));
                    if (chkd)
                        chk("wr_data", rf_wr_data & bmask(ebe[wc]), 32'(ed[wc]));
                end
                wc++;
            end
            if (done) begin
                dc = cyc;
                er = err;
                chk("busy_at_done", 32'(busy), 32'(0));
            end else begin
                tick();
                cyc++;
            end
        end
        chk("busy_c1", 32'(bsy1), 32'(!trivial));
        chk("done_cycle", 32'(dc), trivial ? 32'(1) : 32'(nw + 3));
        chk("err", 32'(er), 32'(sew == 2'b11));
        chk("wr_count", 32'(wc), trivial ? 32'(0) : 32'(nw));
        if (trivial) chk("no_read", 32'(rf_rd_addr_a), 32'(prev_rd));
        if (chkd && !trivial) begin
            for (int w = 0; w < nw; w++) begin
                logic [31:0] m;
                m = 32'(em[w]);
                chk("rf_final", rf[(bd + w) % 32],
                    (snap[(bd + w) % 32] & ~m) | (32'(ed[w]) & m));
            end
        end
        tick();
        chk("done_pulse", 32'(done), 32'(0));
    endtask

    initial begin
        int cyc, wc, dc, b;
        logic [3:0] last_be;
        bit bad;
        rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        sew_in = '0; vl_in = '0; vs1_base = '0; vs2_base = '0; vd_base = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_wr_en", 32'(rf_wr_en), 32'(0));
        chk("rst_addrs", 32'({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}), 32'(0));
        chk("rst_sew", 32'(mul_sew), 32'(0));
        rst = 1'b0;
        fill_random();

        load(0, 32'h04030201); load(1, 32'h08070605);
        load(8, 32'h02020202); load(9, 32'h02020202);
        run_op(2'b00, 8, 0, 8, 16, 1'b1);
        chk("vec_w0", rf[16], 32'h08060402);
        chk("vec_w1", rf[17], 32'h100E0C0A);
        run_op(2'b00, 5, 0, 8, 20, 1'b1);
        run_op(2'b01, 3, 0, 8, 24, 1'b1);
        run_op(2'b00, 0, 0, 8, 16, 1'b1);
        run_op(2'b11, 4, 0, 8, 16, 1'b1);
        load(2, 32'h00007FFF); load(10, 32'h00000003);
        run_op(2'b10, 2, 2, 10, 31, 1'b1);
        chk("wrap_product", rf[31], 32'h00017FFD);
        run_op(2'b10, 200, 0, 0, 0, 1'b0);
        run_op(2'b01, 255, 3, 7, 11, 1'b0);

        repeat (30) begin
            logic [1:0] s;
            int ep;
            fill_random();
            s  = 2'($urandom_range(0, 3));
            ep = (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
            b  = $urandom_range(0, 31);
            run_op(s, $urandom_range(0, 8 * ep), b, (b + 8) % 32, (b + 16) % 32, 1'b1);
        end

        // Reset while an instruction is in flight.
        sew_in = 2'b00; vl_in = 8'd16; vs1_base = 5'd0; vs2_base = 5'd8; vd_base = 5'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_wr_en", 32'(rf_wr_en), 32'(0));
        rst = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            tick();
            if (done || rf_wr_en || busy) bad = 1'b1;
        end
        chk("midrst_quiet", 32'(bad), 32'(0));

        // start held through busy is ignored; still high in the done cycle launches op 2.
        sew_in = 2'b00; vl_in = 8'd8; vs1_base = 5'd0; vs2_base = 5'd8; vd_base = 5'd16;
        start = 1'b1;
        tick();
        sew_in = 2'b01; vl_in = 8'd3; vs1_base = 5'd4; vs2_base = 5'd12; vd_base = 5'd20;
        cyc = 1; wc = 0; dc = -1;
        while (dc < 0 && cyc < 50) begin
            if (rf_wr_en) wc++;
            if (done) dc = cyc;
            else begin tick(); cyc++; end
        end
        chk("held_done1", 32'(dc), 32'(5));
        chk("held_wr1", 32'(wc), 32'(2));
        tick();
        start = 1'b0;
        cyc = 1; wc = 0; dc = -1; last_be = 4'h0;
        while (dc < 0 && cyc < 50) begin
            if (rf_wr_en) begin wc++; last_be = rf_wr_be; end
            if (done) dc = cyc;
            else begin tick(); cyc++; end
        end
        chk("held_done2", 32'(dc), 32'(5));
        chk("held_wr2", 32'(wc), 32'(2));
        chk("held_be2", 32'(last_be), 32'(4'b0011));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
